pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter / fetch sequencer feeding instruction_mem: drives the 8-bit pc, consumes
//  the decoded opcode and 5-bit address fields that come back in the same cycle, and picks the
//  next pc (sequential, jump, conditional branch, halt). Sits directly upstream of instruction
//  memory; the datapath supplies zero_flag and stall.
// PARAMETERS
//  RESET_VECTOR  8'h00   pc value loaded on reset
//  OP_JMP        3'b110  unconditional jump opcode
//  OP_BRZ        3'b101  branch-if-zero opcode
//  OP_HALT       3'b111  halt opcode
// PORTS
//  clk          in   1   single system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  opcode       in   3   opcode decoded from RAM[pc]
//  address      in   5   target field decoded from RAM[pc]
//  zero_flag    in   1   datapath zero flag, sampled at the clock edge
//  stall        in   1   hold pc and state this cycle
//  resume       in   1   leave HALT; 1-cycle pulse
//  pc           out  8   address presented to instruction memory
//  fetch_valid  out  1   pc/instruction pair is valid this cycle
//  halted       out  1   unit is in HALT
//  instr_count  out  16  retired instructions, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): state=BOOT, pc=RESET_VECTOR, fetch_valid=0, halted=0, instr_count=0.
//   Reset asserted mid-operation aborts everything immediately; no pending update survives.
//  FSM states BOOT, RUN, HALT.
//   BOOT: lasts exactly 1 cycle after rst_n deasserts -> RUN. pc held. fetch_valid=0.
//   RUN: fetch_valid=1. At each edge with stall=0 the current instruction retires:
//     opcode==OP_JMP              -> pc <= {pc[7:5], address} (page-relative)
//     opcode==OP_BRZ & zero_flag  -> pc <= {pc[7:5], address}
//     opcode==OP_BRZ & !zero_flag -> pc <= pc+1
//     opcode==OP_HALT             -> pc held, state <= HALT
//     otherwise                   -> pc <= pc+1, mod 256 (8'hFF wraps to 8'h00)
//    With stall=1: pc, state and instr_count hold; opcode is ignored.
//   HALT: halted=1, fetch_valid=0, pc frozen at the HALT instruction address.
//    resume=1 (and stall=0) -> pc <= pc+1, state <= RUN. resume is ignored outside HALT.
//    resume and stall together in HALT: stall wins; resume must be held or re-pulsed.
//  instr_count: +1 per retired instruction in RUN (HALT counts as retired); saturates at 16'hFFFF.
//  Latency: next pc is visible 1 cycle after the retiring edge; no combinational path from
//   opcode/address to pc (pc is a register output).
//  Jump target to own address (self-loop) is legal; pc is re-fetched every cycle.
//  Branch at pc 8'hFF that is not taken wraps to 8'h00; a taken branch stays on page 7.
// CONFIGURATION
//  PC_TRACE_EN defined: adds outputs last_branch_src[7:0] and branch_taken_cnt[7:0]
//   (wrapping). On each taken OP_JMP/OP_BRZ retire: last_branch_src<=pc,
//   branch_taken_cnt<=+1. Both reset to 0.
//  PC_TRACE_EN undefined: neither port nor register exists; all other behaviour is identical.
// TESTING
//  Reset, release, 3 NOPs -> pc 00 (BOOT, fetch_valid=0), 00, 01, 02, 03; instr_count=3.
//  pc=8'h45, OP_JMP address=5'h1C -> next pc=8'h5C; pc=8'hFF, NOP -> next pc=8'h00.
//  OP_BRZ address=5'h03 at pc=8'h10: zero_flag=1 -> 8'h03; zero_flag=0 -> 8'h11.
//  OP_HALT at pc=8'h20 -> halted=1, pc stays 20 for 10 cycles; resume -> pc=8'h21, RUN.
//  stall=1 for 4 cycles over OP_JMP -> pc/instr_count unchanged; jump taken on the stall=0 edge.
//  rst_n pulsed low mid-run at pc=8'h37 -> pc=RESET_VECTOR that same cycle, count=0;
//   with PC_TRACE_EN also check last_branch_src/branch_taken_cnt after two taken jumps.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter / fetch sequencer sitting directly upstream of instruction
//   memory. It presents pc, takes the opcode/address decoded from RAM[pc] in
//   the same cycle, and selects the next pc: sequential, page-relative jump,
//   branch-if-zero, or halt.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   opcode[2:0]       opcode decoded from RAM[pc]
//   address[4:0]      target field decoded from RAM[pc]
//   zero_flag         datapath zero flag, sampled at the clock edge
//   stall             hold pc, state and instr_count this cycle
//   resume            leave HALT (single-cycle pulse)
//   pc[7:0]           address presented to instruction memory (registered)
//   fetch_valid       pc/instruction pair is valid this cycle
//   halted            unit is in HALT
//   instr_count[15:0] retired instructions, saturating at 16'hFFFF
//
// Optional feature (macro PC_TRACE_EN)
//   Adds last_branch_src[7:0] (pc of the most recent taken JMP/BRZ) and
//   branch_taken_cnt[7:0] (wrapping count of taken JMP/BRZ). Both reset to 0.
//
// States
//   state | meaning
//   BOOT  | one cycle after reset release, pc held, no fetch
//   RUN   | fetching; an instruction retires on every edge without stall
//   HALT  | pc frozen at the HALT instruction until resume
module pc_fetch_unit #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter logic [2:0] OP_JMP       = 3'b110,
  parameter logic [2:0] OP_BRZ       = 3'b101,
  parameter logic [2:0] OP_HALT      = 3'b111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  opcode,
  input  logic [4:0]  address,
  input  logic        zero_flag,
  input  logic        stall,
  input  logic        resume,
  output logic [7:0]  pc,
  output logic        fetch_valid,
  output logic        halted,
`ifdef PC_TRACE_EN
  output logic [7:0]  last_branch_src,
  output logic [7:0]  branch_taken_cnt,
`endif
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;

  logic       branch_taken;
  logic [7:0] branch_target;
  logic [7:0] pc_inc;

  always_comb begin
    branch_taken  = (opcode == OP_JMP) || ((opcode == OP_BRZ) && zero_flag);
    // Targets stay on the current 32-entry page.
    branch_target = {pc[7:5], address};
    pc_inc        = pc + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= BOOT;
      pc               <= RESET_VECTOR;
      fetch_valid      <= 1'b0;
      halted           <= 1'b0;
      instr_count      <= 16'd0;
`ifdef PC_TRACE_EN
      last_branch_src  <= 8'd0;
      branch_taken_cnt <= 8'd0;
`endif
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
          halted      <= 1'b0;
        end

        RUN: begin
          if (!stall) begin
            if (instr_count != 16'hFFFF) begin
              instr_count <= instr_count + 16'd1;
            end
            if (branch_taken) begin
              pc <= branch_target;
`ifdef PC_TRACE_EN
              last_branch_src  <= pc;
              branch_taken_cnt <= branch_taken_cnt + 8'd1;
`endif
            end else if (opcode == OP_HALT) begin
              // HALT retires but pc stays on the HALT instruction.
              state       <= HALT;
              fetch_valid <= 1'b0;
              halted      <= 1'b1;
            end else begin
              pc <= pc_inc;
            end
          end
        end

        HALT: begin
          // stall takes priority over resume; a blocked resume is dropped.
          if (resume && !stall) begin
            pc          <= pc_inc;
            state       <= RUN;
            fetch_valid <= 1'b1;
            halted      <= 1'b0;
          end
        end

        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule
